// File: rtl/mackerel_bus_ctrl.sv
// rtl/mackerel_bus_ctrl.sv - 68000 bus controller for the Mackerel boards
//
// Purpose: divides the source clock for the CPU, overlays ROM at 0x000000
// for the first bus cycles after reset, decodes the fixed memory map into
// chip selects, generates DTACK_N with per-region wait states, raises BERR_N
// from a watchdog, and encodes N_IRQ level-sensitive interrupt requests.
//
// Optional feature: define MACKEREL_AUTOVECTOR_EN to answer every IACK cycle
// with VPA_N (autovector) on the SRAM timing instead of IACK_N + DTACK_N.
//
// Ports:
//   CLK, RST                 source clock; synchronous active-low reset
//   CLK_CPU                  CLK / 2^CLK_DIV_LOG2
//   ADDR[22:0]               CPU A[23:1]
//   AS_N, UDS_N, LDS_N, RW   68000 strobes
//   FC[2:0]                  function code (3'b111 = IACK cycle)
//   DTACK_EXT_N              wired-OR acknowledge from external targets
//   IRQ_N[N_IRQ-1:0]         active-low requests, channel i = level i+1
//   IPL_N[2:0]               registered encoded interrupt level
//   IACK_N[N_IRQ-1:0]        per-channel interrupt acknowledge
//   DTACK_N, BERR_N, VPA_N   bus responses
//   ROM_*_N, SRAM_*_N        byte-lane chip selects
//   DRAM_N, DUART_N, IDE_N   region selects
//   BOOT                     high once the ROM overlay has ended
module mackerel_bus_ctrl #(
  parameter int CLK_DIV_LOG2 = 3,
  parameter int BOOT_CYCLES  = 4,
  parameter int N_IRQ        = 4,
  parameter int ROM_WAIT     = 2,
  parameter int SRAM_WAIT    = 0,
  parameter int BERR_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             CLK_CPU,
  input  logic [22:0]      ADDR,
  input  logic             AS_N,
  input  logic             UDS_N,
  input  logic             LDS_N,
  input  logic             RW,
  input  logic [2:0]       FC,
  input  logic             DTACK_EXT_N,
  input  logic [N_IRQ-1:0] IRQ_N,
  output logic [2:0]       IPL_N,
  output logic [N_IRQ-1:0] IACK_N,
  output logic             DTACK_N,
  output logic             BERR_N,
  output logic             VPA_N,
  output logic             ROM_L_N,
  output logic             ROM_U_N,
  output logic             SRAM_L_N,
  output logic             SRAM_U_N,
  output logic             DRAM_N,
  output logic             DUART_N,
  output logic             IDE_N,
  output logic             BOOT
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;

  // How the current cycle is terminated.
  localparam logic [1:0] K_INT  = 2'd0;  // wait counter, DTACK_N
  localparam logic [1:0] K_EXT  = 2'd1;  // DTACK_EXT_N, DTACK_N
  localparam logic [1:0] K_SPUR = 2'd2;  // nothing answers; watchdog only
  localparam logic [1:0] K_AUTO = 2'd3;  // wait counter, VPA_N

  localparam logic [7:0] ROM_WAIT_L  = 8'(ROM_WAIT);
  localparam logic [7:0] SRAM_WAIT_L = 8'(SRAM_WAIT);
  localparam logic [3:0] BOOT_L      = 4'(BOOT_CYCLES);
  localparam logic [9:0] BERR_L      = 10'(BERR_TIMEOUT);
  localparam logic [3:0] NIRQ_L      = 4'(N_IRQ);

  logic [CLK_DIV_LOG2-1:0] div_q, div_d;
  logic                    as_prev_q, as_prev_d;
  logic [3:0]              boot_cnt_q, boot_cnt_d;
  logic                    boot_q, boot_d;
  logic                    dtack_ext_q, dtack_ext_d;
  state_t                  state_q, state_d;
  logic [7:0]              wait_q, wait_d;
  logic [9:0]              wd_q, wd_d;
  logic [1:0]              kind_q, kind_d;
  logic                    iack_q, iack_d;
  logic [2:0]              lvl_q, lvl_d;
  logic [2:0]              ipl_q, ipl_d;
  logic                    dtack_n_q, dtack_n_d;
  logic                    berr_n_q, berr_n_d;
  logic                    vpa_n_q, vpa_n_d;

  logic       is_iack, cyc_mem;
  logic       r_sram, r_dram, r_rom, r_duart, r_ide;
  logic       sel_rom, sel_sram;
  logic [2:0] iack_lvl;
  logic       iack_in_range;
  logic [1:0] start_kind;
  logic [7:0] start_wait;
  logic [9:0] wd_inc;
  logic       ack_now;
  logic [2:0] irq_lvl;

  // RW plays no part in decode; A[13:4] only matter inside the 16K regions.
  logic [10:0] unused_bits;
  assign unused_bits = {RW, ADDR[12:3]};

  // Address decode and chip selects (combinational, AS_N gated).
  always_comb begin
    is_iack  = (FC == 3'b111);
    cyc_mem  = !AS_N && !is_iack;
    r_sram   = (ADDR[22:19] == 4'h0);
    r_rom    = (ADDR[22:19] == 4'hF) && (ADDR[18:14] != 5'h1F);
    r_duart  = (ADDR[22:13] == 10'h3FE);
    r_ide    = (ADDR[22:13] == 10'h3FF);
    r_dram   = !r_sram && (ADDR[22:19] != 4'hF);
    // Before BOOT every access lands in ROM so the reset vectors come from it.
    sel_rom  = cyc_mem && (!boot_q || r_rom);
    sel_sram = cyc_mem && boot_q && r_sram;
    ROM_U_N  = !(sel_rom && !UDS_N);
    ROM_L_N  = !(sel_rom && !LDS_N);
    SRAM_U_N = !(sel_sram && !UDS_N);
    SRAM_L_N = !(sel_sram && !LDS_N);
    DRAM_N   = !(cyc_mem && boot_q && r_dram);
    DUART_N  = !(cyc_mem && boot_q && r_duart && !LDS_N);
    IDE_N    = !(cyc_mem && boot_q && r_ide);

    iack_lvl      = ADDR[2:0];
    iack_in_range = (iack_lvl != 3'd0) && ({1'b0, iack_lvl} <= NIRQ_L);

    start_kind = K_EXT;
    start_wait = 8'd0;
    if (is_iack) begin
`ifdef MACKEREL_AUTOVECTOR_EN
      start_kind = K_AUTO;
      start_wait = SRAM_WAIT_L;
`else
      start_kind = iack_in_range ? K_EXT : K_SPUR;
`endif
    end else if (!boot_q || r_rom) begin
      start_kind = K_INT;
      start_wait = ROM_WAIT_L;
    end else if (r_sram) begin
      start_kind = K_INT;
      start_wait = SRAM_WAIT_L;
    end
  end

  // Next-state logic: divider, boot overlay, interrupt encoder, cycle FSM.
  always_comb begin
    div_d       = div_q + CLK_DIV_LOG2'(1);
    as_prev_d   = AS_N;
    dtack_ext_d = DTACK_EXT_N;

    boot_cnt_d = boot_cnt_q;
    if (!boot_q && AS_N && !as_prev_q && (boot_cnt_q != BOOT_L))
      boot_cnt_d = boot_cnt_q + 4'd1;
    boot_d = boot_q || (boot_cnt_q == BOOT_L);

    // Later channels overwrite earlier ones, so the highest level wins.
    irq_lvl = 3'd0;
    for (int i = 0; i < N_IRQ; i++)
      if (!IRQ_N[i]) irq_lvl = 3'(i + 1);
    ipl_d = ~irq_lvl;

    state_d = state_q;
    wait_d  = wait_q;
    wd_d    = wd_q;
    kind_d  = kind_q;
    iack_d  = iack_q;
    lvl_d   = lvl_q;
    wd_inc  = wd_q + 10'd1;
    ack_now = ((kind_q == K_INT || kind_q == K_AUTO) && (wait_q == 8'd0)) ||
              ((kind_q == K_EXT) && !dtack_ext_q);

    if (AS_N) begin
      state_d = IDLE;
      iack_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          wait_d  = start_wait;
          wd_d    = 10'd0;
          kind_d  = start_kind;
          iack_d  = is_iack && iack_in_range && (start_kind == K_EXT);
          lvl_d   = iack_lvl;
        end
        WAIT: begin
          wd_d = wd_inc;
          // Ack is tested first so a same-edge timeout never wins.
          if (ack_now)
            state_d = ACK;
          else if (wd_inc == BERR_L)
            state_d = BERR;
          else if (wait_q != 8'd0)
            wait_d = wait_q - 8'd1;
        end
        default: state_d = state_q;
      endcase
    end

    dtack_n_d = !((state_d == ACK) && (kind_d != K_AUTO));
    vpa_n_d   = !((state_d == ACK) && (kind_d == K_AUTO));
    berr_n_d  = !(state_d == BERR);
  end

  always_comb begin
    IACK_N = '1;
    for (int i = 0; i < N_IRQ; i++)
      if (iack_q && (lvl_q == 3'(i + 1))) IACK_N[i] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      div_q       <= '0;
      as_prev_q   <= 1'b1;
      boot_cnt_q  <= 4'd0;
      boot_q      <= 1'b0;
      dtack_ext_q <= 1'b1;
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      wd_q        <= 10'd0;
      kind_q      <= K_INT;
      iack_q      <= 1'b0;
      lvl_q       <= 3'd0;
      ipl_q       <= 3'b111;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      vpa_n_q     <= 1'b1;
    end else begin
      div_q       <= div_d;
      as_prev_q   <= as_prev_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_q      <= boot_d;
      dtack_ext_q <= dtack_ext_d;
      state_q     <= state_d;
      wait_q      <= wait_d;
      wd_q        <= wd_d;
      kind_q      <= kind_d;
      iack_q      <= iack_d;
      lvl_q       <= lvl_d;
      ipl_q       <= ipl_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      vpa_n_q     <= vpa_n_d;
    end
  end

  assign CLK_CPU = div_q[CLK_DIV_LOG2-1];
  assign BOOT    = boot_q;
  assign IPL_N   = ipl_q;
  assign DTACK_N = dtack_n_q;
  assign BERR_N  = berr_n_q;
  assign VPA_N   = vpa_n_q;

endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// tb/tb_mackerel_bus_ctrl.sv - directed scoreboard bench for mackerel_bus_ctrl
module tb_mackerel_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLK_CPU;
  logic [22:0] ADDR;
  logic        AS_N, UDS_N, LDS_N, RW;
  logic [2:0]  FC;
  logic        DTACK_EXT_N;
  logic [3:0]  IRQ_N;
  logic [2:0]  IPL_N;
  logic [3:0]  IACK_N;
  logic        DTACK_N, BERR_N, VPA_N;
  logic        ROM_L_N, ROM_U_N, SRAM_L_N, SRAM_U_N;
  logic        DRAM_N, DUART_N, IDE_N;
  logic        BOOT;

  mackerel_bus_ctrl dut (
    .CLK(CLK), .RST(RST), .CLK_CPU(CLK_CPU), .ADDR(ADDR),
    .AS_N(AS_N), .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW), .FC(FC),
    .DTACK_EXT_N(DTACK_EXT_N), .IRQ_N(IRQ_N), .IPL_N(IPL_N), .IACK_N(IACK_N),
    .DTACK_N(DTACK_N), .BERR_N(BERR_N), .VPA_N(VPA_N),
    .ROM_L_N(ROM_L_N), .ROM_U_N(ROM_U_N), .SRAM_L_N(SRAM_L_N), .SRAM_U_N(SRAM_U_N),
    .DRAM_N(DRAM_N), .DUART_N(DUART_N), .IDE_N(IDE_N), .BOOT(BOOT)
  );

  always #5 CLK = ~CLK;

  logic [6:0] sels;
  logic [2:0] resp;
  assign sels = {ROM_U_N, ROM_L_N, SRAM_U_N, SRAM_L_N, DRAM_N, DUART_N, IDE_N};
  assign resp = {~VPA_N, ~BERR_N, ~DTACK_N};

`ifdef MACKEREL_AUTOVECTOR_EN
  localparam bit AUTOVEC = 1'b1;
`else
  localparam bit AUTOVEC = 1'b0;
`endif

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  // Decode table: byte address, LDS_N, expected {ROM_U,ROM_L,SRAM_U,SRAM_L,DRAM,DUART,IDE}.
  logic [23:0] dec_addr [11] = '{24'h000000, 24'h0FFFFE, 24'h100000, 24'hEFFFFE,
                                 24'hF00000, 24'hFF7FFE, 24'hFF8000, 24'hFFBFFE,
                                 24'hFFC000, 24'h000000, 24'hFF8000};
  logic        dec_lds  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1};
  logic [6:0]  dec_exp  [11] = '{7'h67, 7'h67, 7'h7B, 7'h7B, 7'h1F, 7'h1F, 7'h7D,
                                 7'h7D, 7'h7E, 7'h6F, 7'h7F};

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cycle(input logic [23:0] a, input logic [2:0] fc,
                             input logic uds, input logic lds);
    ADDR  = a[23:1];
    FC    = fc;
    UDS_N = uds;
    LDS_N = lds;
    RW    = 1'b1;
    AS_N  = 1'b0;
    #1;
  endtask

  // Edge index e counts from the first edge sampling AS_N low (e = 0).
  task automatic wait_resp(input int e0, input int ext_at, output int lat, output int code);
    lat  = -1;
    code = 0;
    for (int e = e0; e < 400; e++) begin
      if (e == ext_at) DTACK_EXT_N = 1'b0;
      step();
      if (resp != 3'b000) begin
        lat  = e;
        code = int'(resp);
        break;
      end
    end
  endtask

  task automatic finish_cycle();
    AS_N        = 1'b1;
    UDS_N       = 1'b1;
    LDS_N       = 1'b1;
    DTACK_EXT_N = 1'b1;
    expect_val("release", 32'd0);
    step();
    check_next(32'(resp));
    step();
  endtask

  task automatic bus_read(input string tag, input logic [23:0] a, input int ext_at,
                          input int exp_lat, input int exp_code);
    int lat, code;
    expect_val({tag, "_lat"}, 32'(exp_lat));
    expect_val({tag, "_code"}, 32'(exp_code));
    start_cycle(a, 3'b101, 1'b0, 1'b0);
    wait_resp(0, ext_at, lat, code);
    check_next(32'(lat));
    check_next(32'(code));
    finish_cycle();
  endtask

  initial begin
    int lat, code, rise;
    RST = 1'b0; AS_N = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1; RW = 1'b1;
    FC = 3'b101; ADDR = '0; DTACK_EXT_N = 1'b1; IRQ_N = 4'hF;
    repeat (3) step();

    expect_val("rst_clk_cpu", 32'd0);
    expect_val("rst_boot", 32'd0);
    expect_val("rst_ipl", 32'd7);
    expect_val("rst_iack", 32'hF);
    expect_val("rst_resp", 32'd0);
    check_next(32'(CLK_CPU));
    check_next(32'(BOOT));
    check_next(32'(IPL_N));
    check_next(32'(IACK_N));
    check_next(32'(resp));

    // Divider: MSB of a 3-bit counter first rises 4 edges after reset.
    RST = 1'b1;
    rise = -1;
    expect_val("clk_cpu_first_rise", 32'd4);
    for (int e = 1; e <= 16; e++) begin
      step();
      if (CLK_CPU === 1'b1) begin
        rise = e;
        break;
      end
    end
    check_next(32'(rise));

    // Boot overlay: four ROM reads at 0, the fifth hits SRAM.
    for (int n = 0; n < 5; n++) begin
      expect_val("boot_sel", (n < 4) ? 32'h1F : 32'h67);
      expect_val("boot_flag", (n < 4) ? 32'd0 : 32'd1);
      expect_val("boot_lat", (n < 4) ? 32'd3 : 32'd1);
      expect_val("boot_code", 32'd1);
      start_cycle(24'h000000, 3'b101, 1'b0, 1'b0);
      check_next(32'(sels));
      check_next(32'(BOOT));
      wait_resp(0, -1, lat, code);
      check_next(32'(lat));
      check_next(32'(code));
      finish_cycle();
    end

    // Memory-map boundaries and lane gating, checked without an edge.
    for (int i = 0; i < 11; i++) begin
      expect_val("decode", 32'(dec_exp[i]));
      start_cycle(dec_addr[i], 3'b101, 1'b0, dec_lds[i]);
      check_next(32'(sels));
      AS_N = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1;
      step();
    end

    bus_read("rom_wait", 24'hF00000, -1, 3, 1);
    bus_read("sram_wait", 24'h000100, -1, 1, 1);
    bus_read("dram_ext", 24'h200000, 10, 11, 1);
    bus_read("dram_berr", 24'h200000, -1, 255, 2);
    bus_read("ack_vs_timeout", 24'h200000, 254, 255, 1);

    // Interrupt encoding: channels 0 and 2 -> level 3.
    IRQ_N = 4'b1010;
    #1;
    expect_val("ipl_before_edge", 32'd7);
    check_next(32'(IPL_N));
    step();
    expect_val("ipl", 32'd4);
    check_next(32'(IPL_N));

    // Vectored IACK at level 3.
    expect_val("iack_sel", 32'h7F);
    expect_val("iack_n", AUTOVEC ? 32'hF : 32'hB);
    expect_val("iack_lat", AUTOVEC ? 32'd1 : 32'd4);
    expect_val("iack_code", AUTOVEC ? 32'd4 : 32'd1);
    start_cycle(24'hFFFFF6, 3'b111, 1'b0, 1'b0);
    check_next(32'(sels));
    step();
    check_next(32'(IACK_N));
    wait_resp(1, 3, lat, code);
    check_next(32'(lat));
    check_next(32'(code));
    finish_cycle();

    // Spurious IACK at level 6.
    expect_val("spur_iack_n", 32'hF);
    expect_val("spur_lat", AUTOVEC ? 32'd1 : 32'd255);
    expect_val("spur_code", AUTOVEC ? 32'd4 : 32'd2);
    start_cycle(24'hFFFFFC, 3'b111, 1'b0, 1'b0);
    step();
    check_next(32'(IACK_N));
    wait_resp(1, -1, lat, code);
    check_next(32'(lat));
    check_next(32'(code));
    finish_cycle();

    IRQ_N = 4'hF;
    step();
    expect_val("ipl_clear", 32'd7);
    check_next(32'(IPL_N));

    // Reset in the middle of a DRAM wait.
    start_cycle(24'h200000, 3'b101, 1'b0, 1'b0);
    step();
    step();
    RST = 1'b0;
    step();
    expect_val("rst_mid_resp", 32'd0);
    expect_val("rst_mid_boot", 32'd0);
    check_next(32'(resp));
    check_next(32'(BOOT));
    AS_N = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1; RST = 1'b1;
    step();
    expect_val("rst_overlay_sel", 32'h1F);
    expect_val("rst_overlay_lat", 32'd3);
    start_cycle(24'h000000, 3'b101, 1'b0, 1'b0);
    check_next(32'(sels));
    wait_resp(0, -1, lat, code);
    check_next(32'(lat));
    finish_cycle();

    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
